instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction address width.
REQ-002 SHALL have parameter IW, default 32, instruction width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pc_in  input  WIDTH  current instruction address from the program counter.
REQ-006 SHALL have port pc_scr  output  7  PC control: opcode of the instruction being accepted, or 7'h7F to hold the PC.
REQ-007 SHALL have port imem_req  output  1  instruction memory read request.
REQ-008 SHALL have port imem_addr  output  WIDTH  read address.
REQ-009 SHALL have port imem_rdata  input  IW  read data, valid when imem_ready=1.
REQ-010 SHALL have port imem_ready  input  1  memory completes the request this cycle.
REQ-011 SHALL have port if_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 SHALL have port if_pc  output  WIDTH  address of the instruction in IF/ID.
REQ-013 SHALL have port if_instr  output  IW  instruction in IF/ID.
REQ-014 SHALL have port id_ready  input  1  decode consumes IF/ID this cycle when if_valid=1.
REQ-015 SHALL have port halted  output  1  halt instruction fetched; fetch stopped.

Function
REQ-016 SHALL hold internal state: IF/ID register (if_valid, if_pc, if_instr), one-entry skid register (skid_valid, skid_pc, skid_instr), pending flag, halted flag.
REQ-017 SHALL drive imem_addr = pc_in combinationally at all times.
REQ-018 SHALL assert imem_req when rst=1 and halted=0, and either pending=1 or skid_valid=0.
REQ-019 SHALL set pending at the edge where imem_req=1 and imem_ready=0; clear it at the edge where imem_req=1 and imem_ready=1. A request, once raised, stays high until completed.
REQ-020 SHALL define a fetch as imem_req=1 and imem_ready=1 in the same cycle.
REQ-021 SHALL drive pc_scr combinationally: imem_rdata[6:0] in a fetch cycle, otherwise 7'h7F, so the PC advances by exactly one per fetch and holds otherwise.
REQ-022 SHALL drive pc_scr = 7'h7F in a fetch cycle whose imem_rdata[6:0] = 7'h7F (halt), so the PC stays on the halt instruction.
REQ-023 SHALL treat the IF/ID register as free in a cycle when if_valid=0 or id_ready=1.
REQ-024 SHALL load IF/ID, when free, in priority order: skid contents (then skid_valid<=0); else fetched {pc_in, imem_rdata}; else if_valid<=0.
REQ-025 SHALL write a fetch into the skid register when IF/ID is not free or skid_valid=1 and IF/ID takes the skid contents this cycle.
REQ-026 SHALL never lose or duplicate a fetched instruction; delivery to decode is in fetch order.
REQ-027 SHALL hold if_valid, if_pc, if_instr stable while if_valid=1 and id_ready=0.
REQ-028 SHALL set halted at the edge of a fetch with imem_rdata[6:0] = 7'h7F; the halt instruction itself is delivered to IF/ID normally.
REQ-029 SHALL, once halted=1, issue no further requests and keep pc_scr = 7'h7F until reset; queued instructions still drain.
REQ-030 SHALL sustain one fetch per cycle with zero-wait memory and id_ready=1 (pc_in 0,1,2,... on consecutive cycles).
REQ-031 SHALL ignore imem_ready and imem_rdata when imem_req=0.

Reset
REQ-032 SHALL, while rst=0, clear if_valid, skid_valid, pending and halted, and set if_pc, if_instr, skid_pc, skid_instr to 0.
REQ-033 SHALL, while rst=0, drive imem_req=0 and pc_scr=7'h7F.
REQ-034 SHALL abandon any in-flight request on reset; a late imem_ready after release is treated only as part of a new request.
REQ-035 SHALL issue its first request in the first cycle with rst=1.

Verification
REQ-036 Zero-wait memory returns 0x00000013, 0x00100093, 0x00200113 with id_ready=1 -> if_pc 0,1,2 on consecutive cycles; pc_scr = 7'h13 each fetch cycle.
REQ-037 imem_ready delayed 3 cycles -> imem_req held high 4 cycles; pc_scr=7'h7F for 3 cycles, then 7'h13; PC advances once.
REQ-038 id_ready=0 for 4 cycles while fetching -> one fetch goes to skid, requests stop, IF/ID stable; after id_ready=1, both instructions delivered in order.
REQ-039 Fetch of 0x0000007F at address 5 -> halted=1 next cycle, pc_scr=7'h7F thereafter, PC stays 5, if_instr=0x0000007F delivered, no further imem_req.
REQ-040 rst=0 for one cycle during a pending request with skid full -> next cycle if_valid=0, skid empty, halted=0, imem_req=0; request restarts at PC 0 on release.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues memory reads at the external PC, fills the IF/ID register,
// and catches an overflow fetch in a one-entry skid buffer so no instruction is ever dropped.
module instruction_fetch #(
    parameter int WIDTH = 32,
    parameter int IW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic [6:0]       pc_scr,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [IW-1:0]    imem_rdata,
    input  logic             imem_ready,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [IW-1:0]    if_instr,
    input  logic             id_ready,
    output logic             halted
);

    localparam logic [6:0] PC_HOLD = 7'h7F;

    logic             skid_valid;
    logic [WIDTH-1:0] skid_pc;
    logic [IW-1:0]    skid_instr;
    logic             pending;
    logic             fetch;
    logic             free;
    logic             is_halt;

    // A new request is only raised when the skid has room; a raised request is held until served.
    always_comb begin
        imem_addr = pc_in;
        imem_req  = rst & ~halted & (pending | ~skid_valid);
        fetch     = imem_req & imem_ready;
        is_halt   = (imem_rdata[6:0] == PC_HOLD);
        pc_scr    = fetch ? imem_rdata[6:0] : PC_HOLD;
        free      = ~if_valid | id_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
            pending    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            if (imem_req)
                pending <= ~imem_ready;
            if (fetch && is_halt)
                halted <= 1'b1;

            if (free) begin
                if (skid_valid) begin
                    // Older skid entry goes first; a same-cycle fetch refills the skid behind it.
                    if_valid <= 1'b1;
                    if_pc    <= skid_pc;
                    if_instr <= skid_instr;
                    if (fetch) begin
                        skid_pc    <= pc_in;
                        skid_instr <= imem_rdata;
                    end
                    skid_valid <= fetch;
                end else if (fetch) begin
                    if_valid <= 1'b1;
                    if_pc    <= pc_in;
                    if_instr <= imem_rdata;
                end else begin
                    if_valid <= 1'b0;
                end
            end else if (fetch) begin
                skid_valid <= 1'b1;
                skid_pc    <= pc_in;
                skid_instr <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, wait states, decode stall, halt and reset.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [6:0]  pc_scr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        halted;

    int total = 0;
    int bad   = 0;

    instruction_fetch #(.WIDTH(32), .IW(32)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_scr(pc_scr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .id_ready(id_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic [31:0] pc, input logic rdy,
                          input logic [31:0] data, input logic idr);
        @(negedge clk);
        rst = r; pc_in = pc; imem_ready = rdy; imem_rdata = data; id_ready = idr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; pc_in = '0; imem_ready = 1'b0; imem_rdata = '0; id_ready = 1'b1;

        // Reset state
        set_in(1'b0, 32'h33, 1'b1, 32'h13, 1'b1);
        chk("rst_req", imem_req, 0);
        chk("rst_scr", pc_scr, 7'h7F);
        chk("rst_addr", imem_addr, 32'h33);
        tick();
        chk("rst_valid", if_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 0);

        // Zero-wait streaming
        set_in(1'b1, 32'd0, 1'b1, 32'h00000013, 1'b1);
        chk("s0_req", imem_req, 1);
        chk("s0_scr", pc_scr, 7'h13);
        tick();
        chk("s0_valid", if_valid, 1);
        chk("s0_pc", if_pc, 0);
        chk("s0_instr", if_instr, 32'h00000013);
        set_in(1'b1, 32'd1, 1'b1, 32'h00100093, 1'b1);
        chk("s1_scr", pc_scr, 7'h13);
        tick();
        chk("s1_pc", if_pc, 1);
        chk("s1_instr", if_instr, 32'h00100093);
        set_in(1'b1, 32'd2, 1'b1, 32'h00200113, 1'b1);
        chk("s2_scr", pc_scr, 7'h13);
        tick();
        chk("s2_pc", if_pc, 2);
        chk("s2_instr", if_instr, 32'h00200113);

        // Three wait states then completion
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'd3, 1'b0, 32'hDEADBEEF, 1'b1);
            chk("w_req", imem_req, 1);
            chk("w_scr", pc_scr, 7'h7F);
            tick();
            chk("w_valid", if_valid, 0);
        end
        set_in(1'b1, 32'd3, 1'b1, 32'h00300193, 1'b1);
        chk("w3_req", imem_req, 1);
        chk("w3_scr", pc_scr, 7'h13);
        tick();
        chk("w3_valid", if_valid, 1);
        chk("w3_pc", if_pc, 3);

        // Decode stall: next fetch lands in the skid, requests stop
        set_in(1'b1, 32'd4, 1'b1, 32'h00400213, 1'b0);
        chk("st_scr", pc_scr, 7'h13);
        tick();
        chk("st_pc", if_pc, 3);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'd5, 1'b1, 32'h00000013, 1'b0);
            chk("st_req", imem_req, 0);
            chk("st_hold_scr", pc_scr, 7'h7F);
            tick();
            chk("st_hold_valid", if_valid, 1);
            chk("st_hold_pc", if_pc, 3);
            chk("st_hold_instr", if_instr, 32'h00300193);
        end
        set_in(1'b1, 32'd5, 1'b1, 32'h00000013, 1'b1);
        chk("dr_req", imem_req, 0);
        tick();
        chk("dr_pc", if_pc, 4);
        chk("dr_instr", if_instr, 32'h00400213);

        // Halt instruction at address 5
        set_in(1'b1, 32'd5, 1'b1, 32'h0000007F, 1'b1);
        chk("h_req", imem_req, 1);
        chk("h_scr", pc_scr, 7'h7F);
        tick();
        chk("h_halted", halted, 1);
        chk("h_pc", if_pc, 5);
        chk("h_instr", if_instr, 32'h0000007F);
        set_in(1'b1, 32'd5, 1'b1, 32'h00000013, 1'b1);
        chk("h_noreq", imem_req, 0);
        chk("h_scr2", pc_scr, 7'h7F);
        tick();
        chk("h_drained", if_valid, 0);
        chk("h_still", halted, 1);

        // Reset with skid full and IF/ID occupied
        set_in(1'b0, 32'd0, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b1, 32'd0, 1'b0, 32'h0, 1'b0);
        chk("r_first_req", imem_req, 1);
        tick();
        set_in(1'b1, 32'd0, 1'b1, 32'h00000013, 1'b0);
        tick();
        set_in(1'b1, 32'd1, 1'b1, 32'h00100093, 1'b0);
        tick();
        set_in(1'b1, 32'd2, 1'b1, 32'h00200113, 1'b0);
        chk("r_full_req", imem_req, 0);
        set_in(1'b0, 32'd2, 1'b1, 32'h00200113, 1'b0);
        chk("r_rst_req", imem_req, 0);
        chk("r_rst_scr", pc_scr, 7'h7F);
        tick();
        chk("r_valid", if_valid, 0);
        chk("r_halted", halted, 0);
        set_in(1'b1, 32'd0, 1'b0, 32'h0, 1'b1);
        chk("r_restart_req", imem_req, 1);
        chk("r_restart_addr", imem_addr, 0);
        tick();
        set_in(1'b1, 32'd0, 1'b1, 32'h00000013, 1'b1);
        tick();
        chk("r_new_valid", if_valid, 1);
        chk("r_new_pc", if_pc, 0);
        chk("r_new_instr", if_instr, 32'h00000013);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
